// File: rtl/inst_encode_loader.sv
// inst_encode_loader: packs decoded RV32I fields into instruction words and
// streams them into IMEM at consecutive word addresses through a two-stage
// pipeline (S1 = encoded word, S2 = IMEM write-port register).
module inst_encode_loader #(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] num_inst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    fmt,
  input  logic [6:0]    opcode,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [31:0]   imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] err_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_num, r_acc_cnt, r_wr_cnt, r_err_cnt;
  logic [AW-1:0]   r_waddr, r_addr_p2;
  logic            r_vld_p1, r_vld_p2, r_err;
  logic [31:0]     r_word_p1, r_word_p2;
  logic            w_start_acc, w_in_xfer, w_mem_acc, w_adv_p1, w_last_wr;
  logic [32:0]     w_enc;
  logic            w_unused_base;

  // Encode one instruction; returns {error, word}. Errors substitute a NOP.
  function automatic logic [32:0] encode(input logic [2:0] f, input logic [6:0] op,
                                         input logic [4:0] d, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    logic        e;
    w = 32'h0;
    e = 1'b0;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, op};
      3'd1: begin
        w = {im[11:0], s1, f3, d, op};
        e = (im[31:11] != {21{im[31]}});
      end
      3'd2: begin
        w = {im[11:5], s2, s1, f3, im[4:0], op};
        e = (im[31:11] != {21{im[31]}});
      end
      3'd3: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = im[0] || (im[31:12] != {20{im[31]}});
      end
      3'd4: begin
        w = {im[31:12], d, op};
        e = (im[11:0] != 12'h000);
      end
      3'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = im[0] || (im[31:20] != {12{im[31]}});
      end
      default: e = 1'b1;
    endcase
    if (e) w = NOP;
    return {e, w};
  endfunction

  assign w_unused_base = ^base_addr[1:0];

  assign w_start_acc = start && (r_state == ST_IDLE);
  assign w_mem_acc   = r_vld_p2 && mem_ready;
  assign w_adv_p1    = r_vld_p1 && (!r_vld_p2 || w_mem_acc);
  assign in_ready    = (r_state == ST_RUN) && (r_acc_cnt < r_num) && (!r_vld_p1 || w_adv_p1);
  assign w_in_xfer   = in_valid && in_ready;
  assign w_last_wr   = w_mem_acc && (r_wr_cnt == r_num - CW'(1));
  assign w_enc       = encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);

  assign mem_we    = r_vld_p2;
  assign mem_addr  = r_addr_p2;
  assign mem_wdata = r_word_p2;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FIN);
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Sequencer next state: a zero-length run goes straight to FIN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_acc) w_state_nxt = (num_inst == '0) ? ST_FIN : ST_RUN;
      ST_RUN:  if (w_last_wr)   w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Run length, accept/write counters and the word-address generator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num     <= '0;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_waddr   <= '0;
    end else if (w_start_acc) begin
      r_num     <= num_inst;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_waddr   <= {base_addr[AW-1:2], 2'b00};
    end else begin
      if (w_in_xfer) r_acc_cnt <= r_acc_cnt + CW'(1);
      if (w_mem_acc) r_wr_cnt  <= r_wr_cnt + CW'(1);
      if (w_adv_p1)  r_waddr   <= r_waddr + AW'(4);
    end
  end

  // S1 -> S2 boundary: stage valids and the IMEM write-port register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_word_p2 <= '0;
      r_addr_p2 <= '0;
    end else begin
      if (w_in_xfer)     r_vld_p1 <= 1'b1;
      else if (w_adv_p1) r_vld_p1 <= 1'b0;
      if (w_adv_p1) begin
        r_vld_p2  <= 1'b1;
        r_word_p2 <= r_word_p1;
        r_addr_p2 <= r_waddr;
      end else if (w_mem_acc) begin
        r_vld_p2 <= 1'b0;
      end
    end
  end

  // Input -> S1 boundary: encoded word capture (data path, no reset)
  always_ff @(posedge clk) begin
    if (w_in_xfer) r_word_p1 <= w_enc[31:0];
  end

  // Sticky error flag and saturating error counter, cleared by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_start_acc) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_in_xfer && w_enc[32]) begin
      r_err <= 1'b1;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_inst_encode_loader.sv
// Bench for inst_encode_loader: directed cases plus randomized bursts with
// random IMEM backpressure, compared against a format-rule reference model.
module tb_inst_encode_loader;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, mem_we, mem_ready, busy, done, err;
  logic [31:0] base_addr, mem_addr, mem_wdata, imm;
  logic [15:0] num_inst, err_cnt;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;

  int n_chk = 0;
  int n_err = 0;

  fld_t        flds[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  always #5 clk = ~clk;

  inst_encode_loader #(.AW(32), .CW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_inst(num_inst),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // IMEM side: record accepted writes, and verify the port holds while stalled
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (prev_stall) begin
        check("stall_addr", mem_addr, prev_addr);
        check("stall_data", mem_wdata, prev_data);
      end
      if (mem_ready) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end
    end
    prev_stall <= rst_n && mem_we && !mem_ready;
    prev_addr  <= mem_addr;
    prev_data  <= mem_wdata;
  end

  // Reference encoder built from the format rules: legal immediate ranges and bit placement
  function automatic void ref_enc(input fld_t f, output logic [31:0] w, output bit e);
    int          v;
    logic [31:0] u, rr;
    v  = $signed(f.imm);
    u  = f.imm;
    rr = (32'(f.rs1) << 15) | (32'(f.f3) << 12) | 32'(f.op);
    e  = 0;
    w  = 32'h0;
    case (f.fmt)
      3'd0: w = (32'(f.f7) << 25) | (32'(f.rs2) << 20) | (32'(f.rd) << 7) | rr;
      3'd1: begin
        e = !(v >= -2048 && v <= 2047);
        w = ((u & 32'hFFF) << 20) | (32'(f.rd) << 7) | rr;
      end
      3'd2: begin
        e = !(v >= -2048 && v <= 2047);
        w = (((u >> 5) & 32'h7F) << 25) | (32'(f.rs2) << 20) | ((u & 32'h1F) << 7) | rr;
      end
      3'd3: begin
        e = !(v >= -4096 && v <= 4095) || ((u & 1) != 0);
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(f.rs2) << 20)
          | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | rr;
      end
      3'd4: begin
        e = (u & 32'hFFF) != 0;
        w = (u & 32'hFFFFF000) | (32'(f.rd) << 7) | 32'(f.op);
      end
      3'd5: begin
        e = !(v >= -(1 << 20) && v <= (1 << 20) - 1) || ((u & 1) != 0);
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
          | (((u >> 12) & 32'hFF) << 12) | (32'(f.rd) << 7) | 32'(f.op);
      end
      default: e = 1;
    endcase
    if (e) w = 32'h0000_0013;
  endfunction

  task automatic add_fld(input logic [2:0] fm, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
    fld_t f;
    f.fmt = fm; f.op = op; f.rd = d; f.rs1 = s1; f.rs2 = s2; f.f3 = f3; f.f7 = f7; f.imm = im;
    flds.push_back(f);
  endtask

  function automatic fld_t gen_fld(input bit legal_only);
    fld_t f;
    int   sel;
    bit   legal;
    sel   = int'($urandom_range(0, 13));
    f.fmt = (sel < 12 || legal_only) ? 3'(sel % 6) : 3'(6 + (sel & 1));
    f.op  = 7'($urandom); f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
    f.f3  = 3'($urandom); f.f7 = 7'($urandom);
    legal = legal_only || ($urandom_range(0, 9) < 7);
    if (!legal) f.imm = $urandom;
    else case (f.fmt)
      3'd1, 3'd2: f.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      3'd3:       f.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      3'd4:       f.imm = $urandom & 32'hFFFFF000;
      3'd5:       f.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
      default:    f.imm = $urandom;
    endcase
    return f;
  endfunction

  task automatic drive_fld(input int idx, input int n);
    if (idx < n) begin
      in_valid = 1'b1;
      fmt = flds[idx].fmt; opcode = flds[idx].op; rd = flds[idx].rd; rs1 = flds[idx].rs1;
      rs2 = flds[idx].rs2; funct3 = flds[idx].f3; funct7 = flds[idx].f7; imm = flds[idx].imm;
    end else begin
      in_valid = 1'b0;
      imm = $urandom;
    end
  endtask

  // rmode: 0 = mem_ready held high, 1 = repeating 1,0,0,1, 2 = random
  task automatic run_burst(input logic [31:0] base, input int n, input int rmode, input bit poke);
    int          idx, cyc, k, nerr;
    bit          xfer, dropped, e;
    logic [31:0] w;
    bit          pat[4] = '{1, 0, 0, 1};
    wr_addr_q.delete();
    wr_data_q.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_inst = 16'(n); mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_cleared", {31'b0, err}, 0);
    check("errcnt_cleared", {16'b0, err_cnt}, 0);
    check("busy_after_start", {31'b0, busy}, 1);
    if (n == 0) begin
      k = 0;
      while (!done && k < 2) begin @(posedge clk); #1; k++; end
      check("zero_done", {31'b0, done}, 1);
      @(posedge clk); #1; @(posedge clk); #1;
      check("zero_nowrite", wr_addr_q.size(), 0);
      check("zero_idle", {31'b0, busy}, 0);
      return;
    end
    check("in_ready_after_start", {31'b0, in_ready}, 1);
    idx = 0; cyc = 0; dropped = 0;
    drive_fld(idx, n);
    while (wr_addr_q.size() < n && cyc < 2000) begin
      @(negedge clk);
      xfer = in_valid && in_ready;
      if (in_valid && !in_ready) dropped = 1;
      @(posedge clk); #1;
      if (xfer) idx++;
      drive_fld(idx, n);
      case (rmode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = pat[cyc % 4];
        default: mem_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (poke && cyc == 2) begin start = 1'b1; base_addr = $urandom; num_inst = 16'($urandom); end
      if (poke && cyc == 3) start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    check("burst_timeout", {31'b0, cyc < 2000}, 1);
    check("done_pulse", {31'b0, done}, 1);
    check("busy_in_fin", {31'b0, busy}, 1);
    if (rmode == 0) check("burst_cycles", cyc, n + 2);
    if (rmode == 1) check("in_ready_dropped", {31'b0, dropped}, 1);
    @(posedge clk); #1;
    check("done_cleared", {31'b0, done}, 0);
    check("busy_cleared", {31'b0, busy}, 0);
    check("write_count", wr_addr_q.size(), n);
    nerr = 0;
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      ref_enc(flds[i], w, e);
      if (e) nerr++;
      check("wr_addr", wr_addr_q[i], (base & 32'hFFFFFFFC) + 32'(4 * i));
      check("wr_data", wr_data_q[i], w);
    end
    check("err_flag", {31'b0, err}, {31'b0, nerr > 0});
    check("err_cnt", {16'b0, err_cnt}, nerr);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_inst = '0; in_valid = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    mem_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_err_cnt", {16'b0, err_cnt}, 0);
    #3 rst_n = 1'b1;

    // single addi x1, x0, 5
    flds.delete();
    add_fld(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    run_burst(32'h100, 1, 0, 0);
    if (wr_data_q.size() > 0) begin
      check("tp_addi_addr", wr_addr_q[0], 32'h100);
      check("tp_addi_data", wr_data_q[0], 32'h00500093);
    end

    // lui / jal / beq / add back to back
    flds.delete();
    add_fld(3'd4, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    add_fld(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    add_fld(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    add_fld(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    run_burst(32'h200, 4, 0, 0);
    if (wr_data_q.size() == 4) begin
      check("tp_lui", wr_data_q[0], 32'h12345137);
      check("tp_jal", wr_data_q[1], 32'h008000EF);
      check("tp_beq", wr_data_q[2], 32'hFE208EE3);
      check("tp_add", wr_data_q[3], 32'h002081B3);
      check("tp_add_addr", wr_addr_q[3], 32'h20C);
    end

    // encode errors
    flds.delete();
    add_fld(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
    add_fld(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    add_fld(3'd7, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    run_burst(32'h300, 3, 0, 0);
    check("tp_err_flag", {31'b0, err}, 1);
    check("tp_err_cnt", {16'b0, err_cnt}, 3);
    if (wr_data_q.size() == 3) check("tp_err_nop", wr_data_q[1], 32'h00000013);

    // backpressure burst (start also clears the errors above)
    flds.delete();
    for (int i = 0; i < 6; i++) flds.push_back(gen_fld(1));
    run_burst(32'h400, 6, 1, 0);

    // address wrap and unaligned base
    flds.delete();
    for (int i = 0; i < 2; i++) flds.push_back(gen_fld(1));
    run_burst(32'hFFFFFFFE, 2, 0, 0);
    if (wr_addr_q.size() == 2) begin
      check("wrap_addr0", wr_addr_q[0], 32'hFFFFFFFC);
      check("wrap_addr1", wr_addr_q[1], 32'h00000000);
    end

    // zero-length run
    run_burst(32'h500, 0, 0, 0);

    // reset in the middle of a stalled burst
    flds.delete();
    for (int i = 0; i < 6; i++) flds.push_back(gen_fld(1));
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h800; num_inst = 16'd6; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    drive_fld(0, 6);
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_we", {31'b0, mem_we}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", {31'b0, mem_we}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 0);
    check("mid_rst_addr", mem_addr, 0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    flds.delete();
    for (int i = 0; i < 5; i++) flds.push_back(gen_fld(0));
    run_burst(32'h900, 5, 2, 0);

    // randomized bursts with random backpressure and an ignored start mid-run
    for (int b = 0; b < 8; b++) begin
      int n;
      n = int'($urandom_range(3, 12));
      flds.delete();
      for (int i = 0; i < n; i++) flds.push_back(gen_fld(0));
      run_burst($urandom, n, 2, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
